// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode and FSM state types plus multiplier constants.
// Contents:
//   alu_op_t    - request opcodes; encodings 6 and 7 are illegal
//   alu_state_t - controller FSM states
//   MUL_STEPS   - number of shift-add iterations
//   CNT_W       - width of the multiplier iteration counter
package alu_pkg;
    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_ADD  = 3'd1,
        OP_MUL  = 3'd2,
        OP_STC  = 3'd3,
        OP_CLC  = 3'd4,
        OP_ADC  = 3'd5
    } alu_op_t;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_RESP = 2'd3
    } alu_state_t;
    localparam int MUL_STEPS = 8;
    localparam int CNT_W     = $clog2(MUL_STEPS);
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_start    - load operands and clear the accumulator
//   i_run      - perform one iteration this cycle
//   i_a, i_b   - H-bit multiplicand / multiplier
//   o_prod     - product including the current iteration (valid with o_done)
//   o_done     - high during the final iteration
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int H = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic           i_run,
    input  logic [H-1:0]   i_a,
    input  logic [H-1:0]   i_b,
    output logic [2*H-1:0] o_prod,
    output logic           o_done
);
    logic [2*H-1:0] r_acc;
    logic [2*H-1:0] r_mcand;
    logic [H-1:0]   r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [2*H-1:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    // Product is exposed combinationally so the controller can capture it on the final edge.
    assign o_prod    = w_acc_nxt;
    assign o_done    = i_run && (r_cnt == CNT_W'(MUL_STEPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{H{1'b0}}, i_a};
            r_mplier <= i_b;
            r_cnt    <= '0;
        end else if (i_run) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: request/response ALU controller with carry flag and sequential multiplier.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake; req_op, req_a, req_b latched on it
//   rsp_valid/rsp_ready   - response handshake; rsp_data, rsp_err held until it
//   carry_flg             - architectural carry flag
//   busy                  - high whenever the FSM is not idle
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              carry_flg,
    output logic              busy
);
    localparam int H = DATA_W / 2;

    alu_state_t        r_state;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              r_carry;

    logic              w_req_hs;
    logic              w_is_add;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_exec_data;
    logic              w_exec_carry;
    logic              w_exec_err;
    logic [DATA_W-1:0] w_prod;
    logic              w_mul_done;

    assign w_req_hs  = req_valid && req_ready;
    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    // Response registers are cleared on every exit from RESP, so they read 0 while rsp_valid is low.
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign carry_flg = r_carry;

    always_comb begin
        w_is_add     = (r_op == OP_ADD) || (r_op == OP_ADC);
        w_sum        = {1'b0, r_a} + {1'b0, r_b} + (DATA_W+1)'(r_op == OP_ADC && r_carry);
        w_exec_err   = (r_op > 3'd5);
        w_exec_data  = w_is_add ? w_sum[DATA_W-1:0] : (r_op == OP_PASS) ? r_a : '0;
        w_exec_carry = w_is_add ? w_sum[DATA_W] : (r_op == OP_STC) ? 1'b1 :
                       (r_op == OP_CLC) ? 1'b0 : r_carry;
    end

    alu_mul_seq #(.H(H)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_req_hs && (req_op == OP_MUL)),
        .i_run   (r_state == S_MUL),
        .i_a     (req_a[H-1:0]),
        .i_b     (req_b[H-1:0]),
        .o_prod  (w_prod),
        .o_done  (w_mul_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_carry    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req_hs) begin
                    r_op    <= req_op;
                    r_a     <= req_a;
                    r_b     <= req_b;
                    r_state <= (req_op == OP_MUL) ? S_MUL : S_EXEC;
                end
                S_EXEC: begin
                    r_rsp_data <= w_exec_data;
                    r_rsp_err  <= w_exec_err;
                    r_carry    <= w_exec_carry;
                    r_state    <= S_RESP;
                end
                S_MUL: if (w_mul_done) begin
                    r_rsp_data <= w_prod;
                    r_rsp_err  <= 1'b0;
                    r_state    <= S_RESP;
                end
                default: if (rsp_ready) begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule
